// File: rtl/accum_adder_unit.sv
// accum_adder_unit: multi-mode adder (ADD, SUB, per-channel accumulate,
// read-and-clear) behind a valid/ready handshake with a registered,
// one-cycle-latency result stage. Optional saturation on carry/borrow.
module accum_adder_unit #(
   parameter int WIDTH    = 8,
   parameter int NUM_CH   = 4,
   parameter int SATURATE = 1,
   localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [1:0]        in_op,
   input  logic [CW-1:0]     in_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_sum,
   output logic              out_flag,
   output logic [NUM_CH-1:0] ovf_sticky
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   // Unsigned add; returns {carry, result} with the result clamped to
   // all-ones on carry when saturation is enabled.
   function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH:0] r;
      r = {1'b0, a} + {1'b0, b};
      if ((SATURATE != 0) && r[WIDTH]) begin
         add_op = {1'b1, {WIDTH{1'b1}}};
      end else begin
         add_op = r;
      end
   endfunction

   // Unsigned subtract; returns {borrow, result} with the result clamped to
   // zero on borrow when saturation is enabled.
   function automatic logic [WIDTH:0] sub_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic             brw;
      logic [WIDTH-1:0] r;
      brw = (a < b);
      r   = a - b;
      if ((SATURATE != 0) && brw) begin
         sub_op = {1'b1, {WIDTH{1'b0}}};
      end else begin
         sub_op = {brw, r};
      end
   endfunction

   logic [WIDTH-1:0]  r_acc [NUM_CH];
   logic [NUM_CH-1:0] r_ovf;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_sum;
   logic              r_out_flag;

   logic              w_accept;
   logic              w_ch_hit;
   logic [WIDTH-1:0]  w_acc_rd;
   logic [WIDTH:0]    w_arith;
   logic [WIDTH-1:0]  w_res_sum;
   logic              w_res_flag;
   logic              w_acc_we;
   logic [WIDTH-1:0]  w_acc_wdata;
   logic              w_ovf_set;
   logic              w_ovf_clr;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign out_valid  = r_out_valid;
   assign out_sum    = r_out_sum;
   assign out_flag   = r_out_flag;
   assign ovf_sticky = r_ovf;

   // Select the addressed accumulator with an AND-OR mux; an out-of-range
   // channel matches nothing, so the read is zero and w_ch_hit stays low.
   always_comb begin
      w_acc_rd = {WIDTH{1'b0}};
      w_ch_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_ch_hit = w_ch_hit | (in_ch == CW'(i));
         w_acc_rd = w_acc_rd | (r_acc[i] & {WIDTH{in_ch == CW'(i)}});
      end
   end

   // Compute the beat's result and the accumulator/sticky side effects.
   always_comb begin
      w_arith     = {(WIDTH+1){1'b0}};
      w_res_sum   = {WIDTH{1'b0}};
      w_res_flag  = 1'b0;
      w_acc_we    = 1'b0;
      w_acc_wdata = {WIDTH{1'b0}};
      w_ovf_set   = 1'b0;
      w_ovf_clr   = 1'b0;
      case (in_op)
         OP_ADD: begin
            w_arith    = add_op(in_a, in_b);
            w_res_sum  = w_arith[WIDTH-1:0];
            w_res_flag = w_arith[WIDTH];
         end
         OP_SUB: begin
            w_arith    = sub_op(in_a, in_b);
            w_res_sum  = w_arith[WIDTH-1:0];
            w_res_flag = w_arith[WIDTH];
         end
         OP_ACC: begin
            if (w_ch_hit) begin
               w_arith     = add_op(w_acc_rd, in_a);
               w_res_sum   = w_arith[WIDTH-1:0];
               w_res_flag  = w_arith[WIDTH];
               w_acc_we    = 1'b1;
               w_acc_wdata = w_arith[WIDTH-1:0];
               w_ovf_set   = w_arith[WIDTH];
            end else begin
               w_res_sum  = {WIDTH{1'b0}};
               w_res_flag = 1'b0;
            end
         end
         OP_CLR: begin
            if (w_ch_hit) begin
               w_res_sum   = w_acc_rd;
               w_res_flag  = 1'b0;
               w_acc_we    = 1'b1;
               w_acc_wdata = {WIDTH{1'b0}};
               w_ovf_clr   = 1'b1;
            end else begin
               w_res_sum  = {WIDTH{1'b0}};
               w_res_flag = 1'b0;
            end
         end
         default: begin
            w_res_sum  = {WIDTH{1'b0}};
            w_res_flag = 1'b0;
         end
      endcase
   end

   // Output stage, accumulators and sticky flags; all updates on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= {WIDTH{1'b0}};
         r_out_flag  <= 1'b0;
         r_ovf       <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            r_acc[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_res_sum;
            r_out_flag  <= w_res_flag;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_accept && w_acc_we && (in_ch == CW'(i))) begin
               r_acc[i] <= w_acc_wdata;
            end
            if (w_accept && w_ovf_set && (in_ch == CW'(i))) begin
               r_ovf[i] <= 1'b1;
            end else if (w_accept && w_ovf_clr && (in_ch == CW'(i))) begin
               r_ovf[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_accum_adder_unit.sv
// Bench for accum_adder_unit: directed scenarios plus a randomized run,
// all checked against an arithmetic model of accumulators and output stage.
module tb_accum_adder_unit;

   localparam int W    = 8;
   localparam int MAXV = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_a, in_b;
   logic [1:0] in_op;
   logic [1:0] in_ch;
   logic       out_ready;

   logic       in_ready, out_valid, out_flag;
   logic [7:0] out_sum;
   logic [3:0] ovf_sticky;

   logic       wr_in_ready, wr_out_valid, wr_out_flag;
   logic [7:0] wr_out_sum;
   logic [3:0] wr_ovf;

   logic       d3_in_ready, d3_out_valid, d3_out_flag;
   logic [7:0] d3_out_sum;
   logic [2:0] d3_ovf;

   int checks = 0;
   int errors = 0;

   int         m_acc [4];
   logic [3:0] m_ovf;

   always #5 clk = ~clk;

   accum_adder_unit #(.WIDTH(8), .NUM_CH(4), .SATURATE(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_ch(in_ch),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_flag(out_flag), .ovf_sticky(ovf_sticky));

   accum_adder_unit #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) u_dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(wr_in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_ch(in_ch),
      .out_valid(wr_out_valid), .out_ready(out_ready), .out_sum(wr_out_sum),
      .out_flag(wr_out_flag), .ovf_sticky(wr_ovf));

   accum_adder_unit #(.WIDTH(8), .NUM_CH(3), .SATURATE(1)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d3_in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_ch(in_ch),
      .out_valid(d3_out_valid), .out_ready(out_ready), .out_sum(d3_out_sum),
      .out_flag(d3_out_flag), .ovf_sticky(d3_ovf));

   // Reference model of one accepted beat (saturating, 4 channels).
   task automatic model_step(input int op, input int a, input int b, input int ch,
                             output int s, output int f);
      case (op)
         0: begin
            s = a + b; f = (s > MAXV) ? 1 : 0;
            if (f == 1) s = MAXV;
         end
         1: begin
            f = (a < b) ? 1 : 0;
            s = (f == 1) ? 0 : a - b;
         end
         2: begin
            s = m_acc[ch] + a; f = (s > MAXV) ? 1 : 0;
            if (f == 1) begin s = MAXV; m_ovf[ch] = 1'b1; end
            m_acc[ch] = s;
         end
         default: begin
            s = m_acc[ch]; f = 0;
            m_acc[ch] = 0; m_ovf[ch] = 1'b0;
         end
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
      m_ovf = 4'b0000;
   endtask

   task automatic set_beat(input int op, input int a, input int b, input int ch);
      in_valid = 1'b1;
      in_op    = 2'(op);
      in_a     = 8'(a);
      in_b     = 8'(b);
      in_ch    = 2'(ch);
   endtask

   task automatic idle_drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = 8'h00; in_b = 8'h00; in_op = 2'b00; in_ch = 2'b00;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", out_sum); end
      checks++; if (out_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", out_flag); end
      checks++; if (ovf_sticky !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf_sticky); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      int a, b, s, f;
      for (int k = 0; k < 8; k++) begin
         a = (k == 0) ? 'hF0 : int'($urandom_range(0, 255));
         b = (k == 0) ? 'h20 : int'($urandom_range(0, 255));
         set_beat(0, a, b, 0);
         model_step(0, a, b, 0, s, f);
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
         checks++; if (out_sum !== 8'(s) || out_flag !== f[0]) begin
            errors++; $display("FAIL add_sat: a=%h b=%h got %h/%b want %h/%b", a, b, out_sum, out_flag, 8'(s), f[0]);
         end
         checks++; if (wr_out_sum !== 8'(a + b) || wr_out_flag !== ((a + b) > MAXV)) begin
            errors++; $display("FAIL add_wrap: a=%h b=%h got %h/%b want %h/%b", a, b, wr_out_sum, wr_out_flag, 8'(a + b), ((a + b) > MAXV));
         end
      end
      idle_drain();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_sub();
      int a, b, s, f;
      for (int k = 0; k < 8; k++) begin
         a = (k == 0) ? 'h05 : (k == 1) ? 'h09 : int'($urandom_range(0, 255));
         b = (k == 0) ? 'h09 : (k == 1) ? 'h05 : int'($urandom_range(0, 255));
         set_beat(1, a, b, 3);
         model_step(1, a, b, 3, s, f);
         @(posedge clk); #1;
         checks++; if (out_sum !== 8'(s) || out_flag !== f[0]) begin
            errors++; $display("FAIL sub: a=%h b=%h got %h/%b want %h/%b", a, b, out_sum, out_flag, 8'(s), f[0]);
         end
      end
      idle_drain();
      checks++; if (ovf_sticky !== m_ovf) begin errors++; $display("FAIL sub_ovf: got %b want %b", ovf_sticky, m_ovf); end
   endtask

   task automatic test_acc_sat();
      int vals [3];
      int s, f;
      vals[0] = 'h80; vals[1] = 'h70; vals[2] = 'h20;
      for (int k = 0; k < 3; k++) begin
         set_beat(2, vals[k], int'($urandom_range(0, 255)), 2);
         model_step(2, vals[k], 0, 2, s, f);
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_sum !== 8'(s) || out_flag !== f[0]) begin
            errors++; $display("FAIL acc_ch2: step %0d got %b/%h/%b want 1/%h/%b", k, out_valid, out_sum, out_flag, 8'(s), f[0]);
         end
      end
      checks++; if (ovf_sticky !== m_ovf) begin errors++; $display("FAIL acc_ovf: got %b want %b", ovf_sticky, m_ovf); end
      set_beat(3, 0, 0, 2);
      model_step(3, 0, 0, 2, s, f);
      @(posedge clk); #1;
      checks++; if (out_sum !== 8'(s) || out_flag !== 1'b0) begin
         errors++; $display("FAIL clr_sum: got %h/%b want %h/0", out_sum, out_flag, 8'(s));
      end
      checks++; if (ovf_sticky !== m_ovf) begin errors++; $display("FAIL clr_ovf: got %b want %b", ovf_sticky, m_ovf); end
      set_beat(2, 'h11, 0, 2);
      model_step(2, 'h11, 0, 2, s, f);
      @(posedge clk); #1;
      checks++; if (out_sum !== 8'(s)) begin errors++; $display("FAIL clr_then_acc: got %h want %h", out_sum, 8'(s)); end
      idle_drain();
   endtask

   task automatic test_backpressure();
      int a1, b1, a2, b2, s1, f1, s2, f2;
      a1 = int'($urandom_range(0, 255)); b1 = int'($urandom_range(0, 255));
      a2 = int'($urandom_range(0, 255)); b2 = int'($urandom_range(0, 255));
      out_ready = 1'b0;
      set_beat(0, a1, b1, 0);
      model_step(0, a1, b1, 0, s1, f1);
      @(posedge clk); #1;
      set_beat(0, a2, b2, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: cycle %0d got %b want 0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_sum !== 8'(s1) || out_flag !== f1[0]) begin
            errors++; $display("FAIL bp_hold: cycle %0d got %b/%h/%b want 1/%h/%b", k, out_valid, out_sum, out_flag, 8'(s1), f1[0]);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
      model_step(0, a2, b2, 0, s2, f2);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'(s2) || out_flag !== f2[0]) begin
         errors++; $display("FAIL bp_next: got %b/%h/%b want 1/%h/%b", out_valid, out_sum, out_flag, 8'(s2), f2[0]);
      end
      idle_drain();
   endtask

   task automatic test_streaming();
      int s, f;
      out_ready = 1'b1;
      set_beat(3, 0, 0, 0);
      model_step(3, 0, 0, 0, s, f);
      @(posedge clk); #1;
      for (int k = 1; k <= 16; k++) begin
         set_beat(2, 1, 0, 0);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: beat %0d got %b want 1", k, in_ready); end
         model_step(2, 1, 0, 0, s, f);
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_sum !== 8'(k) || s != k) begin
            errors++; $display("FAIL stream: beat %0d got %b/%h want 1/%h", k, out_valid, out_sum, 8'(k));
         end
      end
      idle_drain();
   endtask

   task automatic test_bad_channel();
      int s, f;
      set_beat(2, 5, 0, 3);
      model_step(2, 5, 0, 3, s, f);
      @(posedge clk); #1;
      checks++; if (d3_out_valid !== 1'b1 || d3_out_sum !== 8'h00 || d3_out_flag !== 1'b0) begin
         errors++; $display("FAIL badch_acc: got %b/%h/%b want 1/00/0", d3_out_valid, d3_out_sum, d3_out_flag);
      end
      checks++; if (out_sum !== 8'(s)) begin errors++; $display("FAIL ch3_acc: got %h want %h", out_sum, 8'(s)); end
      set_beat(3, 0, 0, 3);
      model_step(3, 0, 0, 3, s, f);
      @(posedge clk); #1;
      checks++; if (d3_out_sum !== 8'h00 || d3_out_flag !== 1'b0) begin
         errors++; $display("FAIL badch_clr: got %h/%b want 00/0", d3_out_sum, d3_out_flag);
      end
      idle_drain();
   endtask

   task automatic test_reset_midstream();
      int s, f;
      set_beat(3, 0, 0, 1);
      model_step(3, 0, 0, 1, s, f);
      @(posedge clk); #1;
      set_beat(2, 'h33, 0, 1);
      model_step(2, 'h33, 0, 1, s, f);
      @(posedge clk); #1;
      checks++; if (out_sum !== 8'h33) begin errors++; $display("FAIL rstm_setup: got %h want 33", out_sum); end
      out_ready = 1'b0;
      rst = 1'b1;
      set_beat(2, 1, 0, 1);
      @(posedge clk); #1;
      model_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid: got %b want 0", out_valid); end
      checks++; if (ovf_sticky !== 4'b0000) begin errors++; $display("FAIL rstm_ovf: got %b want 0000", ovf_sticky); end
      rst = 1'b0;
      out_ready = 1'b1;
      model_step(2, 1, 0, 1, s, f);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'(s)) begin
         errors++; $display("FAIL rstm_acc: got %b/%h want 1/%h", out_valid, out_sum, 8'(s));
      end
      idle_drain();
   endtask

   task automatic test_random();
      logic m_vld;
      int   m_sum, m_flag, s, f;
      logic exp_ready;
      m_vld = 1'b0; m_sum = 0; m_flag = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         set_beat(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = !m_vld || out_ready;
         checks++; if (in_ready !== exp_ready) begin
            errors++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, in_ready, exp_ready);
         end
         if (in_valid && exp_ready) begin
            model_step(int'(in_op), int'(in_a), int'(in_b), int'(in_ch), s, f);
            m_vld = 1'b1; m_sum = s; m_flag = f;
         end else if (out_ready) begin
            m_vld = 1'b0;
         end
         @(posedge clk); #1;
         checks++; if (out_valid !== m_vld) begin
            errors++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, out_valid, m_vld);
         end
         if (m_vld) begin
            checks++; if (out_sum !== 8'(m_sum) || out_flag !== m_flag[0]) begin
               errors++; $display("FAIL rnd_result: cyc %0d got %h/%b want %h/%b", cyc, out_sum, out_flag, 8'(m_sum), m_flag[0]);
            end
         end
         checks++; if (ovf_sticky !== m_ovf) begin
            errors++; $display("FAIL rnd_ovf: cyc %0d got %b want %b", cyc, ovf_sticky, m_ovf);
         end
      end
      idle_drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_acc_sat();
      test_backpressure();
      test_streaming();
      test_bad_channel();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
